dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
Parametrised successor to the decode stage's stall and target logic: a buffered dispatch stage between decode and the reservation stations / ROB. It holds up to DEPTH decoded instructions in program order and dispatches the head when the ROB and the head's execution unit both have room. It performs writeback wakeup on queued operands, so entries never dispatch stale tags. It replaces the combinational stall path with a registered queue and a flush capability.

Parameters:
DEPTH, 4, queue entries (>=2, need not be a power of 2)
DATA_W, 32, operand value width
TAG_W, 5, ROB tag width; tag 0 = value ready
OP_W, 6, micro-op code width
UNIT_NUM, 4, number of execution units / reservation stations
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous queue clear (mispredict/exception)
in_valid  in  1  decoded instruction offered
in_ex_unit  in  $clog2(UNIT_NUM)  target execution unit
in_op  in  OP_W  micro-op
in_tag  in  2xTAG_W  source operand tags [1:2]
in_val  in  2xDATA_W  source operand values [1:2]
stall_if  out  1  queue full; upstream holds instruction
wd  in  DATA_W  writeback data
w_tag  in  TAG_W  writeback tag; 0 = no writeback
rob_tag  in  TAG_W  next free ROB tag
rob_full  in  1  ROB cannot allocate
rs_full  in  UNIT_NUM  per-unit reservation-station full
out_valid  out  1  head dispatched this cycle
out_ex_unit  out  $clog2(UNIT_NUM)  head unit
out_op  out  OP_W  head op
out_tag  out  2xTAG_W  head operand tags, after wakeup
out_val  out  2xDATA_W  head operand values, after wakeup
out_target  out  TAG_W  rob_tag when out_valid, else 0

Behaviour:
- Reset (rst==0, async): head/tail pointers=0, count=0, all entry tags=0; outputs: stall_if=0, out_valid=0, out_target=0, other out_* = 0.
- stall_if = (count==DEPTH), combinational from registered count. No early-full prediction.
- Enqueue: when in_valid && !stall_if && !flush, write the entry at tail; tail advances with explicit wrap (DEPTH-1 -> 0).
- Latency: an entry enqueued in cycle N can dispatch in cycle N+1 at the earliest. There is no empty-queue bypass.
- Dispatch: out_valid = (count!=0) && !rob_full && !rs_full[head.ex_unit] && !flush. Combinational; out_valid means the entry is consumed that edge, and head advances with wrap.
- out_target = rob_tag if out_valid else 0. out_* fields always show the head, and are 0 when the queue is empty.
- Simultaneous enqueue and dispatch: count unchanged. When full, enqueue is refused even if dispatch occurs that cycle.
- Wakeup: for w_tag!=0, every valid entry operand with tag==w_tag captures val<=wd, tag<=0 at the edge.
- Incoming operands matching the same-cycle w_tag are stored as ready with wd.
- Head forwarding: if a head operand tag==w_tag!=0 in the dispatch cycle, out_val=wd and out_tag=0 combinationally.
- Flush: synchronous. Pointers and count go to 0 at the edge; the same-cycle enqueue and dispatch are suppressed. A flush while full deasserts stall_if next cycle.
- Reset mid-operation discards all entries immediately. No partial dispatch occurs.
- All pointer and count arithmetic is unsigned. count width is $clog2(DEPTH+1).

Decomposition:
- Shared package dispatch_pkg: entry struct typedef (ex_unit, op, tag[1:2], val[1:2]) and constant TAG_READY=0.
- One sub-module: operand_wakeup. It takes a (tag, val) pair plus (w_tag, wd) and returns the updated pair. It is instantiated per operand for the storage, input and head-forward paths.

Test Plan:
- Reset/basic: rst low, then enqueue op=0x03 unit 1 tags {0,0} vals {5,7}; rob_tag=9 -> next cycle out_valid=1, out_target=9, out_val={5,7}; out_target=0 afterwards.
- Fill/stall: DEPTH=4, rs_full[0]=1, enqueue 4 unit-0 ops -> stall_if=1 after 4th; a 5th in_valid is not stored; release rs_full -> dispatch in order, stall_if drops the cycle after the first dispatch.
- Wakeup in queue: entry tag1=6 blocked by rob_full; w_tag=6 wd=0xABCD -> later dispatch shows out_tag[1]=0, out_val[1]=0xABCD.
- Same-cycle capture: in_tag2=3 with w_tag=3 wd=0x11 in the enqueue cycle -> dispatch shows tag2=0, val2=0x11. Head forward: head tag1=4, w_tag=4 in the dispatch cycle -> out_val[1]=wd.
- Wrap/simultaneous: DEPTH=3, enqueue+dispatch every cycle for 10 instructions -> order preserved across pointer wrap, count stays 1.
- Flush/async reset: 3 entries, flush with in_valid=1 -> count=0, nothing dispatched, new entry not stored. Repeat with rst asserted mid-cycle -> outputs 0 immediately.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types for the dispatch queue: the stored entry layout and the ready-tag encoding.
package dispatch_pkg;

  localparam int DQ_DATA_W   = 32;
  localparam int DQ_TAG_W    = 5;
  localparam int DQ_OP_W     = 6;
  localparam int DQ_UNIT_NUM = 4;
  localparam int DQ_REG_W    = 5;
  localparam int DQ_UNIT_W   = $clog2(DQ_UNIT_NUM);

  // A tag of zero marks an operand whose value is already present.
  localparam int TAG_READY = 0;

  typedef struct packed {
    logic [DQ_UNIT_W-1:0]           ex_unit;
    logic [DQ_OP_W-1:0]             op;
    logic [1:2][DQ_TAG_W-1:0]       tag;
    logic [1:2][DQ_DATA_W-1:0]      val;
  } entry_t;

endpackage

// File: rtl/operand_wakeup.sv
// Single-operand writeback wakeup: a pending tag matching the broadcast tag
// becomes ready and takes the broadcast value.
module operand_wakeup
  import dispatch_pkg::*;
#(
  parameter int TAG_W  = DQ_TAG_W,
  parameter int DATA_W = DQ_DATA_W
) (
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] val,
  input  logic [TAG_W-1:0]  w_tag,
  input  logic [DATA_W-1:0] wd,
  output logic [TAG_W-1:0]  tag_upd,
  output logic [DATA_W-1:0] val_upd
);

  logic hit;

  assign hit     = (w_tag != TAG_W'(TAG_READY)) && (tag == w_tag);
  assign tag_upd = hit ? TAG_W'(TAG_READY) : tag;
  assign val_upd = hit ? wd : val;

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch buffer between decode and the reservation stations / ROB,
// with operand wakeup on every stored entry and a synchronous flush.
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = DQ_DATA_W,
  parameter int TAG_W    = DQ_TAG_W,
  parameter int OP_W     = DQ_OP_W,
  parameter int UNIT_NUM = DQ_UNIT_NUM,
  parameter int REG_W    = DQ_REG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [$clog2(UNIT_NUM)-1:0] in_ex_unit,
  input  logic [OP_W-1:0]             in_op,
  input  logic [1:2][TAG_W-1:0]       in_tag,
  input  logic [1:2][DATA_W-1:0]      in_val,
  output logic                        stall_if,
  input  logic [DATA_W-1:0]           wd,
  input  logic [TAG_W-1:0]            w_tag,
  input  logic [TAG_W-1:0]            rob_tag,
  input  logic                        rob_full,
  input  logic [UNIT_NUM-1:0]         rs_full,
  output logic                        out_valid,
  output logic [$clog2(UNIT_NUM)-1:0] out_ex_unit,
  output logic [OP_W-1:0]             out_op,
  output logic [1:2][TAG_W-1:0]       out_tag,
  output logic [1:2][DATA_W-1:0]      out_val,
  output logic [TAG_W-1:0]            out_target
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // The stored entry layout is fixed by the package; other widths cannot elaborate.
  if (DATA_W != DQ_DATA_W || TAG_W != DQ_TAG_W || OP_W != DQ_OP_W ||
      UNIT_NUM != DQ_UNIT_NUM || REG_W != DQ_REG_W || DEPTH < 2) begin : g_param_check
    $error("dispatch_queue: parameters do not match dispatch_pkg entry layout");
  end

  entry_t            mem [DEPTH];
  entry_t            head_e;
  entry_t            in_entry;
  logic [TAG_W-1:0]  wk_tag [DEPTH][1:2];
  logic [DATA_W-1:0] wk_val [DEPTH][1:2];
  logic [TAG_W-1:0]  in_wk_tag [1:2];
  logic [DATA_W-1:0] in_wk_val [1:2];
  logic [TAG_W-1:0]  hd_tag [1:2];
  logic [DATA_W-1:0] hd_val [1:2];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              empty, enq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_e   = mem[head];
  assign empty    = (count == '0);
  assign stall_if = (count == CNT_W'(DEPTH));
  assign enq      = in_valid && !stall_if && !flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    for (genvar k = 1; k <= 2; k++) begin : g_opnd
      operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_store_wk (
        .tag     (mem[i].tag[k]),
        .val     (mem[i].val[k]),
        .w_tag   (w_tag),
        .wd      (wd),
        .tag_upd (wk_tag[i][k]),
        .val_upd (wk_val[i][k])
      );
    end
  end

  // Incoming operands and the head's operands see the same-cycle writeback.
  for (genvar k = 1; k <= 2; k++) begin : g_path
    operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_in_wk (
      .tag     (in_tag[k]),
      .val     (in_val[k]),
      .w_tag   (w_tag),
      .wd      (wd),
      .tag_upd (in_wk_tag[k]),
      .val_upd (in_wk_val[k])
    );
    operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_head_wk (
      .tag     (head_e.tag[k]),
      .val     (head_e.val[k]),
      .w_tag   (w_tag),
      .wd      (wd),
      .tag_upd (hd_tag[k]),
      .val_upd (hd_val[k])
    );
  end

  always_comb begin
    in_entry         = '0;
    in_entry.ex_unit = in_ex_unit;
    in_entry.op      = in_op;
    for (int k = 1; k <= 2; k++) begin
      in_entry.tag[k] = in_wk_tag[k];
      in_entry.val[k] = in_wk_val[k];
    end
  end

  always_comb begin
    out_valid   = 1'b0;
    out_ex_unit = '0;
    out_op      = '0;
    out_tag     = '0;
    out_val     = '0;
    out_target  = '0;
    if (!empty) begin
      out_ex_unit = head_e.ex_unit;
      out_op      = head_e.op;
      for (int k = 1; k <= 2; k++) begin
        out_tag[k] = hd_tag[k];
        out_val[k] = hd_val[k];
      end
      out_valid = !rob_full && !rs_full[head_e.ex_unit] && !flush;
    end
    if (out_valid) out_target = rob_tag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 1; k <= 2; k++) begin
          mem[i].tag[k] <= wk_tag[i][k];
          mem[i].val[k] <= wk_val[i][k];
        end
      end
      // The tail slot is never the head being read here: enqueue is refused when full.
      if (enq) begin
        mem[tail] <= in_entry;
        tail      <= ptr_inc(tail);
      end
      if (out_valid) head <= ptr_inc(head);
      if (enq && !out_valid)      count <= count + 1'b1;
      else if (!enq && out_valid) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: a DEPTH=4 and a DEPTH=3 instance share stimulus and are
// checked every cycle against a scoreboard queue, plus targeted checks on key events.
module tb_dispatch_queue;
  import dispatch_pkg::*;

  typedef entry_t eq_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [1:0]       in_ex_unit = '0;
  logic [5:0]       in_op = '0;
  logic [1:2][4:0]  in_tag = '0;
  logic [1:2][31:0] in_val = '0;
  logic [31:0]      wd = '0;
  logic [4:0]       w_tag = '0;
  logic [4:0]       rob_tag = '0;
  logic             rob_full = 1'b0;
  logic [3:0]       rs_full = '0;

  logic             s4, v4, s3, v3;
  logic [1:0]       u4, u3;
  logic [5:0]       op4, op3;
  logic [1:2][4:0]  t4, t3;
  logic [1:2][31:0] d4, d3;
  logic [4:0]       g4, g3;

  int   checks = 0;
  int   errors = 0;
  eq_t  sb4, sb3;

  always #5 clk = ~clk;

  dispatch_queue #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ex_unit(in_ex_unit),
    .in_op(in_op), .in_tag(in_tag), .in_val(in_val), .stall_if(s4), .wd(wd), .w_tag(w_tag),
    .rob_tag(rob_tag), .rob_full(rob_full), .rs_full(rs_full), .out_valid(v4),
    .out_ex_unit(u4), .out_op(op4), .out_tag(t4), .out_val(d4), .out_target(g4)
  );

  dispatch_queue #(.DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ex_unit(in_ex_unit),
    .in_op(in_op), .in_tag(in_tag), .in_val(in_val), .stall_if(s3), .wd(wd), .w_tag(w_tag),
    .rob_tag(rob_tag), .rob_full(rob_full), .rs_full(rs_full), .out_valid(v3),
    .out_ex_unit(u3), .out_op(op3), .out_tag(t3), .out_val(d3), .out_target(g3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t wake(input entry_t e);
    entry_t r;
    r = e;
    for (int k = 1; k <= 2; k++)
      if (w_tag != 5'd0 && r.tag[k] == w_tag) begin
        r.tag[k] = 5'd0;
        r.val[k] = wd;
      end
    return r;
  endfunction

  function automatic entry_t cur_in();
    entry_t e;
    e.ex_unit = in_ex_unit;
    e.op      = in_op;
    e.tag     = in_tag;
    e.val     = in_val;
    return wake(e);
  endfunction

  function automatic logic disp(input int sz, input entry_t hd);
    return rst && sz != 0 && !rob_full && !rs_full[hd.ex_unit] && !flush;
  endfunction

  function automatic eq_t step_q(input eq_t q, input int depth);
    eq_t    r;
    entry_t hd;
    logic   pop, push;
    if (!rst || flush) return r;
    hd = '0;
    if (q.size() != 0) hd = q[0];
    pop  = disp(q.size(), hd);
    push = in_valid && q.size() != depth;
    foreach (q[i]) r.push_back(wake(q[i]));
    if (pop) void'(r.pop_front());
    if (push) r.push_back(cur_in());
    return r;
  endfunction

  task automatic check_inst(input string nm, input int depth, input eq_t q, input logic v,
                            input logic s, input logic [1:0] u, input logic [5:0] op,
                            input logic [1:2][4:0] t, input logic [1:2][31:0] d,
                            input logic [4:0] g);
    entry_t hd, e;
    logic   ev;
    hd = '0;
    if (q.size() != 0) hd = q[0];
    e = '0;
    if (q.size() != 0) e = wake(hd);
    ev = disp(q.size(), hd);
    chk({nm, ".valid"}, v, ev);
    chk({nm, ".stall"}, s, q.size() == depth);
    chk({nm, ".unit"}, u, e.ex_unit);
    chk({nm, ".op"}, op, e.op);
    chk({nm, ".tag"}, t, e.tag);
    chk({nm, ".val"}, d, e.val);
    chk({nm, ".target"}, g, ev ? rob_tag : 5'd0);
  endtask

  task automatic settle();
    @(negedge clk);
    check_inst("d4", 4, sb4, v4, s4, u4, op4, t4, d4, g4);
    check_inst("d3", 3, sb3, v3, s3, u3, op3, t3, d3, g3);
  endtask

  task automatic commit();
    @(posedge clk);
    sb4 = step_q(sb4, 4);
    sb3 = step_q(sb3, 3);
    #1;
  endtask

  task automatic cyc();
    settle();
    commit();
  endtask

  task automatic drive(input logic [1:0] u, input logic [5:0] op, input logic [4:0] ta,
                       input logic [4:0] tb, input logic [31:0] va, input logic [31:0] vb);
    in_valid   = 1'b1;
    in_ex_unit = u;
    in_op      = op;
    in_tag[1]  = ta;
    in_tag[2]  = tb;
    in_val[1]  = va;
    in_val[2]  = vb;
  endtask

  initial begin
    // reset
    repeat (2) cyc();
    chk("rst_stall", s4, 1'b0);
    chk("rst_valid", v4, 1'b0);
    rst = 1'b1;

    // basic enqueue then dispatch next cycle
    rob_tag = 5'd9;
    drive(2'd1, 6'h03, 5'd0, 5'd0, 32'd5, 32'd7);
    settle();
    chk("basic_nobypass", v4, 1'b0);
    commit();
    in_valid = 1'b0;
    settle();
    chk("basic_valid", v4, 1'b1);
    chk("basic_target", g4, 5'd9);
    chk("basic_val1", d4[1], 32'd5);
    chk("basic_val2", d4[2], 32'd7);
    chk("basic_op", op4, 6'h03);
    commit();
    settle();
    chk("basic_target_after", g4, 5'd0);
    commit();

    // fill and stall
    rs_full = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 6'h10 + 6'(i), 5'd0, 5'd0, 32'(i), 32'(i + 50));
      cyc();
    end
    drive(2'd0, 6'h1F, 5'd0, 5'd0, 32'd99, 32'd99);
    settle();
    chk("fill_stall", s4, 1'b1);
    commit();
    in_valid = 1'b0;
    rs_full  = 4'b0000;
    settle();
    chk("fill_first_op", op4, 6'h10);
    chk("fill_first_valid", v4, 1'b1);
    chk("fill_stall_held", s4, 1'b1);
    commit();
    settle();
    chk("fill_stall_drop", s4, 1'b0);
    chk("fill_second_op", op4, 6'h11);
    commit();
    repeat (2) cyc();
    settle();
    chk("fill_fifth_dropped", v4, 1'b0);
    commit();

    // wakeup while queued
    rob_full = 1'b1;
    drive(2'd2, 6'h21, 5'd6, 5'd0, 32'd0, 32'h22);
    cyc();
    in_valid = 1'b0;
    w_tag    = 5'd6;
    wd       = 32'hABCD;
    cyc();
    w_tag    = 5'd0;
    wd       = 32'h0;
    rob_full = 1'b0;
    settle();
    chk("wake_valid", v4, 1'b1);
    chk("wake_tag1", t4[1], 5'd0);
    chk("wake_val1", d4[1], 32'hABCD);
    commit();

    // same-cycle capture on enqueue
    drive(2'd3, 6'h22, 5'd0, 5'd3, 32'd1, 32'd0);
    w_tag = 5'd3;
    wd    = 32'h11;
    cyc();
    in_valid = 1'b0;
    w_tag    = 5'd0;
    wd       = 32'h0;
    settle();
    chk("cap_tag2", t4[2], 5'd0);
    chk("cap_val2", d4[2], 32'h11);
    commit();

    // head forwarding in the dispatch cycle
    rob_full = 1'b1;
    drive(2'd1, 6'h23, 5'd4, 5'd0, 32'd0, 32'd2);
    cyc();
    in_valid = 1'b0;
    rob_full = 1'b0;
    w_tag    = 5'd4;
    wd       = 32'h4444;
    settle();
    chk("fwd_valid", v4, 1'b1);
    chk("fwd_tag1", t4[1], 5'd0);
    chk("fwd_val1", d4[1], 32'h4444);
    commit();
    w_tag = 5'd0;
    wd    = 32'h0;

    // simultaneous enqueue/dispatch across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(2'(i % 4), 6'h30 + 6'(i), 5'd0, 5'd0, 32'(i), 32'(i + 100));
      rob_tag = 5'(i + 1);
      settle();
      if (i > 0) begin
        chk("wrap_op4", op4, 6'h30 + 6'(i - 1));
        chk("wrap_op3", op3, 6'h30 + 6'(i - 1));
        chk("wrap_target3", g3, 5'(i + 1));
      end
      commit();
    end
    in_valid = 1'b0;
    settle();
    chk("wrap_last_op3", op3, 6'h39);
    commit();
    settle();
    chk("wrap_drained", v3, 1'b0);
    commit();

    // flush with a same-cycle enqueue
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 6'h40 + 6'(i), 5'd0, 5'd0, 32'(i), 32'(i));
      cyc();
    end
    drive(2'd0, 6'h43, 5'd0, 5'd0, 32'd7, 32'd7);
    rob_full = 1'b0;
    flush    = 1'b1;
    settle();
    chk("flush_nodisp", v4, 1'b0);
    commit();
    flush    = 1'b0;
    in_valid = 1'b0;
    settle();
    chk("flush_empty_valid", v4, 1'b0);
    chk("flush_empty_op", op4, 6'h00);
    commit();

    // flush while full
    rob_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'd1, 6'h50 + 6'(i), 5'd0, 5'd0, 32'(i), 32'(i));
      cyc();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    settle();
    chk("flush_full_pre", s4, 1'b1);
    commit();
    flush = 1'b0;
    settle();
    chk("flush_full_post", s4, 1'b0);
    commit();

    // asynchronous reset in mid-cycle
    for (int i = 0; i < 3; i++) begin
      drive(2'd2, 6'h60 + 6'(i), 5'd0, 5'd0, 32'(i), 32'(i));
      cyc();
    end
    in_valid = 1'b0;
    rob_full = 1'b0;
    #1;
    chk("pre_rst_valid", v4, 1'b1);
    chk("pre_rst_op", op4, 6'h60);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", v4, 1'b0);
    chk("rst_mid_op", op4, 6'h00);
    chk("rst_mid_target", g4, 5'd0);
    chk("rst_mid_val", d4, 64'd0);
    sb4.delete();
    sb3.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();

    // normal operation resumes after reset
    rob_tag = 5'd17;
    drive(2'd3, 6'h2A, 5'd0, 5'd0, 32'hBEEF, 32'h1);
    cyc();
    in_valid = 1'b0;
    settle();
    chk("post_rst_op", op4, 6'h2A);
    chk("post_rst_target", g4, 5'd17);
    commit();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
